// File: rtl/sevseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with an inter-digit blanking gap,
// leading-zero blanking and frame-synchronous display updates via a valid/ready port.
module sevseg_scan_ctrl #(
   parameter int N_DIGITS     = 4,
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [4*N_DIGITS-1:0] upd_bcd,
   input  logic                  lzb_en,
   output logic [6:0]            seg_o,
   output logic [N_DIGITS-1:0]   an_o,
   output logic                  frame_done
);

   localparam int CNT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(DIGIT_CYCLES - BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
   localparam logic [6:0]          SEG_OFF = {7{ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{ACTIVE_LOW}};

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } state_t;

   state_t                state, state_nx;
   logic [CNT_W-1:0]      cnt, cnt_nx;
   logic [IDX_W-1:0]      idx, idx_nx;
   logic [4*N_DIGITS-1:0] disp, pend;
   logic                  pend_vld;
   logic                  xfer;
   logic [6:0]            seg_nx, seg_pat, seg_val;
   logic [N_DIGITS-1:0]   an_nx, an_act, onehot;
   logic                  frame_done_nx;
   logic [3:0]            digit [N_DIGITS];
   logic [N_DIGITS-1:0]   lz_blank;

   // Patterns are stored active-low (common anode) and inverted for active-high panels.
   function automatic logic [6:0] encode_al(input logic [3:0] d);
      case (d)
         4'd0:    encode_al = 7'b1000000;
         4'd1:    encode_al = 7'b1111001;
         4'd2:    encode_al = 7'b0100100;
         4'd3:    encode_al = 7'b0110000;
         4'd4:    encode_al = 7'b0011001;
         4'd5:    encode_al = 7'b0010010;
         4'd6:    encode_al = 7'b0000010;
         4'd7:    encode_al = 7'b1111000;
         4'd8:    encode_al = 7'b0000000;
         4'd9:    encode_al = 7'b0010000;
         default: encode_al = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      for (int i = 0; i < N_DIGITS; i++) begin
         digit[i] = disp[4*i +: 4];
      end
   end

   // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
   always_comb begin : lz_scan
      logic zero_above;
      lz_blank   = '0;
      zero_above = 1'b1;
      for (int i = N_DIGITS - 1; i > 0; i--) begin
         zero_above  = zero_above & (digit[i] == 4'd0);
         lz_blank[i] = zero_above;
      end
   end

   always_comb begin
      seg_pat = encode_al(digit[idx]);
      if (lzb_en && lz_blank[idx]) begin
         seg_pat = 7'b1111111;
      end
      seg_val = ACTIVE_LOW ? seg_pat : ~seg_pat;
      onehot  = N_DIGITS'(1) << idx;
      an_act  = ACTIVE_LOW ? ~onehot : onehot;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BLANK;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
      end
   end

   // Outputs are computed for the state being entered, so an_o is active exactly in ON
   // and seg_o only reloads while the anodes are already off.
   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt + CNT_W'(1);
      idx_nx        = idx;
      seg_nx        = seg_o;
      an_nx         = AN_OFF;
      frame_done_nx = 1'b0;
      xfer          = 1'b0;
      case (state)
         BLANK: begin
            if (cnt == '0) begin
               seg_nx = seg_val;
            end
            if (cnt == BLANK_LAST) begin
               state_nx = ON;
               cnt_nx   = '0;
               an_nx    = an_act;
            end
         end
         ON: begin
            an_nx = an_act;
            if (cnt == ON_LAST) begin
               state_nx = BLANK;
               cnt_nx   = '0;
               an_nx    = AN_OFF;
               if (idx == IDX_LAST) begin
                  idx_nx        = '0;
                  frame_done_nx = 1'b1;
                  xfer          = pend_vld;
               end else begin
                  idx_nx = idx + IDX_W'(1);
               end
            end
         end
         default: begin
            state_nx = BLANK;
            cnt_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_o      <= SEG_OFF;
         an_o       <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         seg_o      <= seg_nx;
         an_o       <= an_nx;
         frame_done <= frame_done_nx;
      end
   end

   // Accept needs pend_vld low and transfer needs it high, so the two never coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp     <= '0;
         pend     <= '0;
         pend_vld <= 1'b0;
      end else if (xfer) begin
         disp     <= pend;
         pend_vld <= 1'b0;
      end else if (upd_valid && !pend_vld) begin
         pend     <= upd_bcd;
         pend_vld <= 1'b1;
      end
   end

   assign upd_ready = ~pend_vld;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Self-checking bench for sevseg_scan_ctrl: table of update vectors checked frame by frame
// through an expected-frame queue, plus hand sequences for back-pressure and mid-scan reset.
module tb_sevseg_scan_ctrl;

   localparam int N_DIGITS     = 4;
   localparam int DIGIT_CYCLES = 8;
   localparam int BLANK_CYCLES = 2;
   localparam int FRAME        = N_DIGITS * DIGIT_CYCLES;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        upd_valid = 1'b0;
   logic        lzb_en = 1'b0;
   logic [15:0] upd_bcd = 16'h0000;
   logic        upd_ready;
   logic [6:0]  seg_o;
   logic [3:0]  an_o;
   logic        frame_done;

   always #5 clk = ~clk;

   sevseg_scan_ctrl #(
      .N_DIGITS     (N_DIGITS),
      .DIGIT_CYCLES (DIGIT_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES),
      .ACTIVE_LOW   (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_bcd    (upd_bcd),
      .lzb_en     (lzb_en),
      .seg_o      (seg_o),
      .an_o       (an_o),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [15:0] bcd;
      logic        lzb;
      logic [27:0] segs;
   } vec_t;

   vec_t        vecs [8];
   logic [27:0] exp_q [$];
   int          vec_count = 0;
   int          err_count = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      vec_count++;
      if (act !== want) begin
         err_count++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] bcd, input logic lzb, input logic [27:0] segs);
      upd_bcd   = bcd;
      lzb_en    = lzb;
      upd_valid = 1'b1;
      exp_q.push_back(segs);
   endtask

   task automatic waitFrameDone(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 3 * FRAME);
      checkOutput({tag, " frame_done wait"}, {31'd0, frame_done}, 32'd1);
   endtask

   // Called at the negedge of the first cycle of a frame; samples one full frame.
   task automatic captureFrame(input logic fd0, input logic release_valid, input string tag);
      logic [27:0] segs;
      logic [3:0]  one = 4'b0001;
      logic [3:0]  exp_an;
      int          slot, pos;
      segs = 28'hFFFFFFF;
      if (exp_q.size() > 0) begin
         segs = exp_q.pop_front();
      end
      for (int k = 0; k < FRAME; k++) begin
         slot = k / DIGIT_CYCLES;
         pos  = k % DIGIT_CYCLES;
         if (release_valid && k == 1) begin
            upd_valid = 1'b0;
            checkOutput($sformatf("%s k%0d ready", tag, k), {31'd0, upd_ready}, 32'd0);
         end
         exp_an = (pos < BLANK_CYCLES) ? 4'hF : ~(one << slot);
         checkOutput($sformatf("%s k%0d an", tag, k), {28'd0, an_o}, {28'd0, exp_an});
         if (pos >= 1) begin
            checkOutput($sformatf("%s k%0d seg", tag, k), {25'd0, seg_o},
                        {25'd0, segs[slot*7 +: 7]});
         end
         checkOutput($sformatf("%s k%0d fd", tag, k), {31'd0, frame_done},
                     {31'd0, (k == 0) ? fd0 : 1'b0});
         @(negedge clk);
      end
   endtask

   // seg_o may only change across an edge where the anodes are off before and after.
   logic [6:0] prev_seg = 7'h7F;
   logic [3:0] prev_an  = 4'hF;
   always @(negedge clk) begin
      if (rst_n && prev_seg !== seg_o) begin
         vec_count++;
         if (prev_an !== 4'hF || an_o !== 4'hF) begin
            err_count++;
            $display("[TB] FAIL seg_while_lit: seg %h->%h with an %h->%h",
                     prev_seg, seg_o, prev_an, an_o);
         end
      end
      prev_seg = seg_o;
      prev_an  = an_o;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Expected segments packed {d3, d2, d1, d0}, active-low.
      vecs[0] = '{16'h0407, 1'b1, {7'h7F, 7'h19, 7'h40, 7'h78}};
      vecs[1] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
      vecs[2] = '{16'hF3A9, 1'b1, {7'h7F, 7'h30, 7'h7F, 7'h10}};
      vecs[3] = '{16'h0047, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h78}};
      vecs[4] = '{16'h0050, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}};
      vecs[5] = '{16'h1234, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}};
      vecs[6] = '{16'h8906, 1'b1, {7'h00, 7'h10, 7'h40, 7'h02}};
      vecs[7] = '{16'h0005, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};

      repeat (3) @(negedge clk);
      checkOutput("reset an", {28'd0, an_o}, 32'hF);
      checkOutput("reset seg", {25'd0, seg_o}, 32'h7F);
      checkOutput("reset ready", {31'd0, upd_ready}, 32'd1);
      checkOutput("reset fd", {31'd0, frame_done}, 32'd0);

      exp_q.push_back({4{7'h40}});
      rst_n = 1'b1;
      captureFrame(1'b0, 1'b0, "t1 f0");
      exp_q.push_back({4{7'h40}});
      captureFrame(1'b1, 1'b0, "t1 f1");

      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("v%0d period fd", i), {31'd0, frame_done}, 32'd1);
         repeat (10) @(negedge clk);
         checkOutput($sformatf("v%0d ready idle", i), {31'd0, upd_ready}, 32'd1);
         applyStimulus(vecs[i].bcd, vecs[i].lzb, vecs[i].segs);
         @(negedge clk);
         upd_valid = 1'b0;
         checkOutput($sformatf("v%0d ready busy", i), {31'd0, upd_ready}, 32'd0);
         waitFrameDone($sformatf("v%0d", i));
         checkOutput($sformatf("v%0d ready boundary", i), {31'd0, upd_ready}, 32'd1);
         captureFrame(1'b1, 1'b0, $sformatf("v%0d", i));
      end

      // Back-pressure: a second update waits until the boundary, then both show in turn.
      repeat (5) @(negedge clk);
      applyStimulus(16'h0021, 1'b1, {7'h7F, 7'h7F, 7'h24, 7'h79});
      @(negedge clk);
      upd_valid = 1'b0;
      checkOutput("t4 ready after A", {31'd0, upd_ready}, 32'd0);
      repeat (2) @(negedge clk);
      upd_bcd   = 16'h0300;
      upd_valid = 1'b1;
      @(negedge clk);
      checkOutput("t4 B held off", {31'd0, upd_ready}, 32'd0);
      waitFrameDone("t4 A");
      checkOutput("t4 ready boundary", {31'd0, upd_ready}, 32'd1);
      exp_q.push_back({7'h7F, 7'h30, 7'h40, 7'h40});
      captureFrame(1'b1, 1'b1, "t4 A");
      checkOutput("t4 ready after B", {31'd0, upd_ready}, 32'd1);
      captureFrame(1'b1, 1'b0, "t4 B");

      // Reset while a digit is lit and an update is pending.
      repeat (3) @(negedge clk);
      upd_bcd   = 16'h1234;
      lzb_en    = 1'b0;
      upd_valid = 1'b1;
      @(negedge clk);
      upd_valid = 1'b0;
      checkOutput("t6 pending", {31'd0, upd_ready}, 32'd0);
      repeat (8) @(negedge clk);
      checkOutput("t6 lit before reset", {28'd0, an_o}, 32'hD);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6 reset an", {28'd0, an_o}, 32'hF);
      checkOutput("t6 reset seg", {25'd0, seg_o}, 32'h7F);
      checkOutput("t6 reset ready", {31'd0, upd_ready}, 32'd1);
      checkOutput("t6 reset fd", {31'd0, frame_done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      exp_q.push_back({4{7'h40}});
      rst_n = 1'b1;
      captureFrame(1'b0, 1'b0, "t6 f0");
      exp_q.push_back({4{7'h40}});
      captureFrame(1'b1, 1'b0, "t6 f1");

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
